// File: rtl/run_ctrl_pkg.sv
// Shared types for the run-control sequencer: FSM state encoding and the
// instruction/memory strobe pair driven in each state.
// Pure package, no logic; strobe pairs are {instr_clock, mem_clock}.
package run_ctrl_pkg;

  typedef enum logic [2:0] {
    HALTED  = 3'd0,
    INSTR_H = 3'd1,
    MEM_H   = 3'd2,
    MEM_L   = 3'd3,
    INSTR_L = 3'd4
  } state_t;

  localparam logic [1:0] STB_HALTED  = 2'b00;
  localparam logic [1:0] STB_INSTR_H = 2'b10;
  localparam logic [1:0] STB_MEM_H   = 2'b11;
  localparam logic [1:0] STB_MEM_L   = 2'b10;
  localparam logic [1:0] STB_INSTR_L = 2'b00;

  // Unknown encodings map to the halted pair so a corrupted state never
  // drives a strobe.
  function automatic logic [1:0] strobe_of(input state_t s);
    case (s)
      INSTR_H: strobe_of = STB_INSTR_H;
      MEM_H:   strobe_of = STB_MEM_H;
      MEM_L:   strobe_of = STB_MEM_L;
      INSTR_L: strobe_of = STB_INSTR_L;
      default: strobe_of = STB_HALTED;
    endcase
  endfunction

endpackage

// File: rtl/run_ctrl_wait_timer.sv
// Memory wait-state timer: counts stretched MEM_H cycles, flags the last allowed one.
// Latency: o_expire is combinational from the count register; count updates next edge.
// No flow control; i_clr has priority over i_inc.
//
// Ports: clk, reset (sync, active-high), i_clr (zero the count),
//        i_inc (advance the count), o_expire (count == MAX_WAIT-1, never if MAX_WAIT==0).
module run_ctrl_wait_timer #(
  parameter int MAX_WAIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_expire
);

  localparam int CNT_W = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'((MAX_WAIT > 0) ? MAX_WAIT - 1 : 0);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  generate
    if (MAX_WAIT == 0) begin : g_no_timeout
      // Timeout disabled: the count may wrap harmlessly, it is never compared.
      logic w_unused;
      assign w_unused = ^r_cnt;
      assign o_expire = 1'b0;
    end else begin : g_timeout
      assign o_expire = (r_cnt == LAST);
    end
  endgenerate

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run-control sequencer: four-phase instr/mem strobes with halt, single-step, wait stretch, timeout.
// Latency: 4 clk per instruction plus one per mem_ready=0 cycle in MEM_H; outputs registered.
// Backpressure: mem_ready=0 holds MEM_H; MAX_WAIT stretched cycles raise sticky fault.
//
// Ports: clk, reset (sync, active-high); run, step, halt_req, clear_fault from debug/boot;
//        mem_ready from memory; instr_clock, mem_clock to core/memory; halted, step_done,
//        fault, instr_count status.
// Build option: RUN_CTRL_INSTR_COUNTER_EN implements instr_count; otherwise it is tied to 0.
module cpu_run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = 16,
  parameter int COUNT_W  = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  input  logic               step,
  input  logic               halt_req,
  input  logic               mem_ready,
  input  logic               clear_fault,
  output logic               instr_clock,
  output logic               mem_clock,
  output logic               halted,
  output logic               step_done,
  output logic               fault,
  output logic [COUNT_W-1:0] instr_count
);

  state_t r_state;
  state_t w_state_nxt;

  logic r_instr_clock;
  logic r_mem_clock;
  logic r_halted;
  logic r_step_done;
  logic r_fault;
  logic r_halt_pend;
  logic r_single;

  logic w_single_nxt;
  logic w_step_done_nxt;
  logic w_fault_set;
  logic w_halt_clr;
  logic w_wait_clr;
  logic w_wait_inc;
  logic w_wait_expire;
  logic w_active;

  run_ctrl_wait_timer #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_timer (
    .clk      (clk),
    .reset    (reset),
    .i_clr    (w_wait_clr),
    .i_inc    (w_wait_inc),
    .o_expire (w_wait_expire)
  );

  // halt_req is only meaningful while an instruction is in flight.
  assign w_active = (r_state == INSTR_H) || (r_state == MEM_H) ||
                    (r_state == MEM_L)   || (r_state == INSTR_L);

  always_comb begin
    w_state_nxt     = r_state;
    w_single_nxt    = r_single;
    w_step_done_nxt = 1'b0;
    w_fault_set     = 1'b0;
    w_halt_clr      = 1'b0;
    w_wait_clr      = 1'b0;
    w_wait_inc      = 1'b0;
    case (r_state)
      HALTED: begin
        if (!r_fault) begin
          if (run) begin
            w_state_nxt  = INSTR_H;
            w_single_nxt = 1'b0;
          end else if (step) begin
            w_state_nxt  = INSTR_H;
            w_single_nxt = 1'b1;
          end
        end
      end
      INSTR_H: begin
        w_state_nxt = MEM_H;
        w_wait_clr  = 1'b1;
      end
      MEM_H: begin
        if (mem_ready) begin
          w_state_nxt = MEM_L;
        end else if (w_wait_expire) begin
          // Timeout still finishes the strobe sequence; the halt happens at INSTR_L.
          w_fault_set = 1'b1;
          w_state_nxt = MEM_L;
        end else begin
          w_wait_inc = 1'b1;
        end
      end
      MEM_L: begin
        w_state_nxt = INSTR_L;
      end
      INSTR_L: begin
        if (r_single || r_halt_pend || r_fault || !run) begin
          w_state_nxt = HALTED;
          w_halt_clr  = 1'b1;
          if (r_single) begin
            w_step_done_nxt = 1'b1;
            w_single_nxt    = 1'b0;
          end
        end else begin
          w_state_nxt = INSTR_H;
        end
      end
      default: begin
        // Corrupted encoding: recover exactly as from reset.
        w_state_nxt  = HALTED;
        w_single_nxt = 1'b0;
        w_halt_clr   = 1'b1;
      end
    endcase
  end

  // Outputs are computed from the next state so they change on the same
  // edge that enters the state they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= HALTED;
      r_instr_clock <= 1'b0;
      r_mem_clock   <= 1'b0;
      r_halted      <= 1'b1;
      r_step_done   <= 1'b0;
      r_fault       <= 1'b0;
      r_halt_pend   <= 1'b0;
      r_single      <= 1'b0;
    end else begin
      r_state                      <= w_state_nxt;
      {r_instr_clock, r_mem_clock} <= strobe_of(w_state_nxt);
      r_halted                     <= (w_state_nxt == HALTED);
      r_step_done                  <= w_step_done_nxt;
      r_single                     <= w_single_nxt;
      if (w_fault_set) begin
        r_fault <= 1'b1;
      end else if (clear_fault) begin
        r_fault <= 1'b0;
      end
      if (w_halt_clr) begin
        r_halt_pend <= 1'b0;
      end else if (halt_req && w_active) begin
        r_halt_pend <= 1'b1;
      end
    end
  end

`ifdef RUN_CTRL_INSTR_COUNTER_EN
  logic [COUNT_W-1:0] r_instr_count;

  // Counts every instruction boundary; wraps naturally at 2^COUNT_W.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_instr_count <= '0;
    end else if (r_state == INSTR_L) begin
      r_instr_count <= r_instr_count + 1'b1;
    end
  end

  assign instr_count = r_instr_count;
`else
  assign instr_count = '0;
`endif

  assign instr_clock = r_instr_clock;
  assign mem_clock   = r_mem_clock;
  assign halted      = r_halted;
  assign step_done   = r_step_done;
  assign fault       = r_fault;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl with MAX_WAIT=4: free-run, single-step, wait stretch,
// timeout fault, halt request and mid-instruction reset, each checked by immediate assertions.
// instr_count expectations follow RUN_CTRL_INSTR_COUNTER_EN (0 when undefined).
module tb_cpu_run_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic        step;
  logic        halt_req;
  logic        mem_ready;
  logic        clear_fault;
  logic        instr_clock;
  logic        mem_clock;
  logic        halted;
  logic        step_done;
  logic        fault;
  logic [31:0] instr_count;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef RUN_CTRL_INSTR_COUNTER_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  cpu_run_ctrl #(
    .MAX_WAIT (4),
    .COUNT_W  (32)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .run         (run),
    .step        (step),
    .halt_req    (halt_req),
    .mem_ready   (mem_ready),
    .clear_fault (clear_fault),
    .instr_clock (instr_clock),
    .mem_clock   (mem_clock),
    .halted      (halted),
    .step_done   (step_done),
    .fault       (fault),
    .instr_count (instr_count)
  );

  function automatic logic [31:0] exp_cnt(input int n);
    return CNT_EN ? 32'(n) : 32'd0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected value is {instr_clock, mem_clock, halted}.
  task automatic chk_stb(input string tag, input logic [2:0] e);
    check(tag, {29'd0, instr_clock, mem_clock, halted}, {29'd0, e});
  endtask

  initial begin
    int   cyc;
    int   mhi;
    logic prev_i;
    bit   done;

    reset = 1'b1; run = 1'b0; step = 1'b0; halt_req = 1'b0;
    mem_ready = 1'b1; clear_fault = 1'b0;
    tick();
    tick();
    chk_stb("reset_stb", 3'b001);
    check("reset_step_done", {31'd0, step_done}, 32'd0);
    check("reset_fault", {31'd0, fault}, 32'd0);
    check("reset_count", instr_count, 32'd0);

    // Free run: 1,1,1,0 / 0,1,0,0 strobe pattern.
    reset = 1'b0; run = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk_stb($sformatf("run_seq%0d", i), {(i % 4) != 3, (i % 4) == 1, 1'b0});
      if (i == 8) check("count_after9", instr_count, exp_cnt(2));
    end
    run = 1'b0;
    tick();
    chk_stb("run_stop", 3'b001);
    check("run_stop_count", instr_count, exp_cnt(3));

    // Single step, with a second step during INSTR_H that must be ignored.
    step = 1'b1; tick(); step = 1'b0;
    chk_stb("step_instr_h", 3'b100);
    step = 1'b1; tick(); step = 1'b0;
    chk_stb("step_mem_h", 3'b110);
    tick();
    chk_stb("step_mem_l", 3'b100);
    tick();
    chk_stb("step_instr_l", 3'b000);
    check("step_done_early", {31'd0, step_done}, 32'd0);
    tick();
    chk_stb("step_halted", 3'b001);
    check("step_done_pulse", {31'd0, step_done}, 32'd1);
    check("step_count", instr_count, exp_cnt(4));
    tick();
    chk_stb("step_no_requeue", 3'b001);
    check("step_done_end", {31'd0, step_done}, 32'd0);

    // Three wait states: mem_clock high 4 cycles, period 7.
    run = 1'b1;
    tick();
    chk_stb("wait_instr_h", 3'b100);
    mem_ready = 1'b0; cyc = 0; mhi = 0; prev_i = 1'b1; done = 1'b0;
    while (!done && cyc < 30) begin
      tick();
      cyc++;
      if (mem_clock) mhi++;
      mem_ready = (mhi >= 4);
      if (instr_clock && !mem_clock && !prev_i) done = 1'b1;
      prev_i = instr_clock;
    end
    check("wait_period", cyc, 7);
    check("wait_mem_hi", mhi, 4);
    check("wait_fault", {31'd0, fault}, 32'd0);

    // halt_req in MEM_H: instruction completes, then halts despite run=1.
    tick();
    chk_stb("halt_mem_h", 3'b110);
    halt_req = 1'b1; tick(); halt_req = 1'b0;
    chk_stb("halt_mem_l", 3'b100);
    tick();
    chk_stb("halt_instr_l", 3'b000);
    tick();
    chk_stb("halt_taken", 3'b001);
    run = 1'b0;
    tick();
    halt_req = 1'b1; tick(); halt_req = 1'b0;
    chk_stb("halted_hold", 3'b001);
    run = 1'b1;
    tick(); tick(); tick(); tick();
    chk_stb("stale_instr_l", 3'b000);
    tick();
    chk_stb("no_stale_halt", 3'b100);

    // mem_ready stuck low: timeout after 4th MEM_H cycle.
    mem_ready = 1'b0;
    tick(); tick(); tick(); tick();
    chk_stb("to_mem_h4", 3'b110);
    check("to_fault_before", {31'd0, fault}, 32'd0);
    tick();
    chk_stb("to_mem_l", 3'b100);
    check("to_fault_set", {31'd0, fault}, 32'd1);
    tick();
    chk_stb("to_instr_l", 3'b000);
    tick();
    chk_stb("to_halted", 3'b001);
    tick();
    chk_stb("to_run_ignored", 3'b001);
    check("to_fault_sticky", {31'd0, fault}, 32'd1);
    mem_ready = 1'b1;
    clear_fault = 1'b1; tick(); clear_fault = 1'b0;
    check("to_fault_cleared", {31'd0, fault}, 32'd0);
    chk_stb("to_still_halted", 3'b001);
    tick();
    chk_stb("to_resume", 3'b100);

    // Reset mid-instruction.
    tick();
    chk_stb("rst_mem_h", 3'b110);
    reset = 1'b1; tick();
    chk_stb("rst_abandon", 3'b001);
    check("rst_count", instr_count, 32'd0);
    check("rst_fault", {31'd0, fault}, 32'd0);
    reset = 1'b0; run = 1'b0;
    tick();
    chk_stb("rst_idle", 3'b001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
